// File: rtl/timer_pkg.sv
// timer_pkg
// Shared definitions for the countdown timer sequencer:
//   - state_e      : FSM state encoding (IDLE=0, SET=1, RUN=2, PAUSE=3, ALARM=4)
//   - digit maxima : largest legal value of each BCD digit position
//   - *_OFS        : bit offset of each 4-bit BCD digit in the 24-bit packed
//                    value {hrs1,hrs0,min1,min0,sec1,sec0}
//   - clamp_bcd    : forces an arbitrary 24-bit value into a legal 00:00:00..23:59:59
package timer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SET   = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_ALARM = 3'd4
  } state_e;

  localparam logic [3:0] UNITS_MAX    = 4'd9;
  localparam logic [3:0] TENS_MAX     = 4'd5;
  localparam logic [3:0] HRS1_MAX     = 4'd2;
  localparam logic [3:0] HRS0_MAX_TOP = 4'd3;

  localparam int SEC0_OFS = 0;
  localparam int SEC1_OFS = 4;
  localparam int MIN0_OFS = 8;
  localparam int MIN1_OFS = 12;
  localparam int HRS0_OFS = 16;
  localparam int HRS1_OFS = 20;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max);
    return (d > max) ? max : d;
  endfunction

  // Each digit is saturated independently; then 2x hours are limited to 23
  // so the result is always a legal time of day.
  function automatic logic [23:0] clamp_bcd(input logic [23:0] v);
    logic [23:0] r;
    logic [3:0]  h1;
    logic [3:0]  h0;
    r = '0;
    r[SEC0_OFS +: 4] = clamp_digit(v[SEC0_OFS +: 4], UNITS_MAX);
    r[SEC1_OFS +: 4] = clamp_digit(v[SEC1_OFS +: 4], TENS_MAX);
    r[MIN0_OFS +: 4] = clamp_digit(v[MIN0_OFS +: 4], UNITS_MAX);
    r[MIN1_OFS +: 4] = clamp_digit(v[MIN1_OFS +: 4], TENS_MAX);
    h1 = clamp_digit(v[HRS1_OFS +: 4], HRS1_MAX);
    h0 = clamp_digit(v[HRS0_OFS +: 4], UNITS_MAX);
    if (h1 == HRS1_MAX && h0 > HRS0_MAX_TOP) h0 = HRS0_MAX_TOP;
    r[HRS1_OFS +: 4] = h1;
    r[HRS0_OFS +: 4] = h0;
    return r;
  endfunction

endpackage

// File: rtl/timer_bcd_dec.sv
// timer_bcd_dec
// Combinational one-second decrement of a packed BCD time value.
// Ports:
//   bcd_i  [23:0] : current time {hrs1,hrs0,min1,min0,sec1,sec0}
//   bcd_o  [23:0] : bcd_i minus one second (00:00:00 wraps to 23:59:59)
//   zero_o        : high when bcd_o is 00:00:00
module timer_bcd_dec
  import timer_pkg::*;
(
  input  logic [23:0] bcd_i,
  output logic [23:0] bcd_o,
  output logic        zero_o
);

  logic       borrow;
  logic [3:0] h1;
  logic [3:0] h0;

  // Ripple a borrow up through sec0, sec1, min0, min1 (maxima 9,5,9,5),
  // then treat the hours pair as a decimal 00..23 counter.
  always_comb begin
    bcd_o  = bcd_i;
    borrow = 1'b1;

    if (bcd_i[SEC0_OFS +: 4] == 4'd0) begin
      bcd_o[SEC0_OFS +: 4] = UNITS_MAX;
    end else begin
      bcd_o[SEC0_OFS +: 4] = bcd_i[SEC0_OFS +: 4] - 4'd1;
      borrow = 1'b0;
    end

    if (borrow) begin
      if (bcd_i[SEC1_OFS +: 4] == 4'd0) begin
        bcd_o[SEC1_OFS +: 4] = TENS_MAX;
      end else begin
        bcd_o[SEC1_OFS +: 4] = bcd_i[SEC1_OFS +: 4] - 4'd1;
        borrow = 1'b0;
      end
    end

    if (borrow) begin
      if (bcd_i[MIN0_OFS +: 4] == 4'd0) begin
        bcd_o[MIN0_OFS +: 4] = UNITS_MAX;
      end else begin
        bcd_o[MIN0_OFS +: 4] = bcd_i[MIN0_OFS +: 4] - 4'd1;
        borrow = 1'b0;
      end
    end

    if (borrow) begin
      if (bcd_i[MIN1_OFS +: 4] == 4'd0) begin
        bcd_o[MIN1_OFS +: 4] = TENS_MAX;
      end else begin
        bcd_o[MIN1_OFS +: 4] = bcd_i[MIN1_OFS +: 4] - 4'd1;
        borrow = 1'b0;
      end
    end

    h1 = bcd_i[HRS1_OFS +: 4];
    h0 = bcd_i[HRS0_OFS +: 4];
    if (borrow) begin
      if (h0 != 4'd0) begin
        h0 = h0 - 4'd1;
      end else if (h1 != 4'd0) begin
        h1 = h1 - 4'd1;
        h0 = UNITS_MAX;
      end else begin
        h1 = HRS1_MAX;
        h0 = HRS0_MAX_TOP;
      end
    end
    bcd_o[HRS1_OFS +: 4] = h1;
    bcd_o[HRS0_OFS +: 4] = h0;

    zero_o = (bcd_o == 24'd0);
  end

endmodule

// File: rtl/timer_sequencer.sv
// timer_sequencer
// Countdown timer control FSM with edit mode, pause and a timed alarm.
// Parameter:
//   ALARM_SECS : number of 1 Hz ticks the alarm stays asserted (1..63)
// Ports:
//   clk, rst (async, active low)
//   tick_1hz, start_stop, clear, set_mode : one-clk pulses
//   ld_bcd  [23:0] : value to load when leaving SET (clamped to 23:59:59)
//   cur_bcd [23:0] : remaining time
//   state   [2:0]  : FSM state code
//   running, alarm, edit_en : registered state decodes
// Build option:
//   TIMER_AUTO_RELOAD_EN : keep a shadow of the last load and restart from it
//                          when the alarm times out.
module timer_sequencer
  import timer_pkg::*;
#(
  parameter int ALARM_SECS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_1hz,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        set_mode,
  input  logic [23:0] ld_bcd,
  output logic [23:0] cur_bcd,
  output logic [2:0]  state,
  output logic        running,
  output logic        alarm,
  output logic        edit_en
);

  localparam logic [5:0] ALARM_LOAD = 6'(ALARM_SECS);

  state_e      state_q, state_d;
  logic [23:0] cur_q, cur_d;
  logic [5:0]  alarm_cnt_q, alarm_cnt_d;
  logic        running_q, running_d;
  logic        alarm_q, alarm_d;
  logic        edit_en_q, edit_en_d;
  logic [23:0] dec_bcd;
  logic        dec_zero;
  logic [23:0] load_bcd;
`ifdef TIMER_AUTO_RELOAD_EN
  logic [23:0] shadow_q, shadow_d;
`endif

  timer_bcd_dec u_dec (
    .bcd_i  (cur_q),
    .bcd_o  (dec_bcd),
    .zero_o (dec_zero)
  );

  assign load_bcd = clamp_bcd(ld_bcd);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cur_q       <= '0;
      alarm_cnt_q <= '0;
      running_q   <= 1'b0;
      alarm_q     <= 1'b0;
      edit_en_q   <= 1'b0;
`ifdef TIMER_AUTO_RELOAD_EN
      shadow_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      alarm_cnt_q <= alarm_cnt_d;
      running_q   <= running_d;
      alarm_q     <= alarm_d;
      edit_en_q   <= edit_en_d;
`ifdef TIMER_AUTO_RELOAD_EN
      shadow_q    <= shadow_d;
`endif
    end
  end

  // Next-state logic. clear overrides everything; within each state the
  // inputs are tested in priority order set_mode > start_stop > tick_1hz.
  // set_mode only acts in IDLE/SET and is transparent elsewhere.
  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    alarm_cnt_d = alarm_cnt_q;
`ifdef TIMER_AUTO_RELOAD_EN
    shadow_d    = shadow_q;
`endif

    if (clear) begin
      state_d     = ST_IDLE;
      cur_d       = '0;
      alarm_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (set_mode) begin
            state_d = ST_SET;
          end else if (start_stop && cur_q != 24'd0) begin
            state_d = ST_RUN;
          end
        end

        ST_SET: begin
          if (set_mode) begin
            state_d  = ST_IDLE;
            cur_d    = load_bcd;
`ifdef TIMER_AUTO_RELOAD_EN
            shadow_d = load_bcd;
`endif
          end
        end

        // A tick coinciding with start_stop is dropped.
        ST_RUN: begin
          if (start_stop) begin
            state_d = ST_PAUSE;
          end else if (tick_1hz) begin
            cur_d = dec_bcd;
            if (dec_zero) begin
              state_d     = ST_ALARM;
              alarm_cnt_d = ALARM_LOAD;
            end
          end
        end

        ST_PAUSE: begin
          if (start_stop) state_d = ST_RUN;
        end

        ST_ALARM: begin
          if (start_stop) begin
            state_d     = ST_IDLE;
            cur_d       = '0;
            alarm_cnt_d = '0;
          end else if (tick_1hz) begin
            alarm_cnt_d = alarm_cnt_q - 6'd1;
            // The last alarm tick; <= also covers a count that is already 0.
            if (alarm_cnt_q <= 6'd1) begin
              alarm_cnt_d = '0;
`ifdef TIMER_AUTO_RELOAD_EN
              if (shadow_q != 24'd0) begin
                state_d = ST_RUN;
                cur_d   = shadow_q;
              end else begin
                state_d = ST_IDLE;
                cur_d   = '0;
              end
`else
              state_d = ST_IDLE;
              cur_d   = '0;
`endif
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Decodes are taken from the next state and registered alongside it so
  // the outputs come straight from flops and stay glitch-free.
  always_comb begin
    running_d = (state_d == ST_RUN);
    alarm_d   = (state_d == ST_ALARM);
    edit_en_d = (state_d == ST_SET);
  end

  assign cur_bcd = cur_q;
  assign state   = state_q;
  assign running = running_q;
  assign alarm   = alarm_q;
  assign edit_en = edit_en_q;

endmodule

// File: tb/tb_timer_sequencer.sv
// tb_timer_sequencer
// Scoreboard bench for timer_sequencer. The reference model keeps the
// remaining time as a plain number of seconds and converts to BCD only
// when producing an expectation. Directed scenarios cover the main count,
// hour borrows, load clamping, input priority, alarm duration and reset;
// a randomized phase follows. Honors TIMER_AUTO_RELOAD_EN like the design.
module tb_timer_sequencer;

  localparam int ALARM_SECS = 3;
  localparam logic [2:0] S_IDLE = 3'd0, S_SET = 3'd1, S_RUN = 3'd2,
                         S_PAUSE = 3'd3, S_ALARM = 3'd4;

  logic        clk;
  logic        rst;
  logic        tick_1hz;
  logic        start_stop;
  logic        clear;
  logic        set_mode;
  logic [23:0] ld_bcd;
  logic [23:0] cur_bcd;
  logic [2:0]  state;
  logic        running;
  logic        alarm;
  logic        edit_en;

  timer_sequencer #(.ALARM_SECS(ALARM_SECS)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick_1hz   (tick_1hz),
    .start_stop (start_stop),
    .clear      (clear),
    .set_mode   (set_mode),
    .ld_bcd     (ld_bcd),
    .cur_bcd    (cur_bcd),
    .state      (state),
    .running    (running),
    .alarm      (alarm),
    .edit_en    (edit_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  st;
    logic [23:0] cur;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state
  logic [2:0] m_state;
  int         m_secs;
  int         m_shadow;
  int         m_alarm_left;

  function automatic int clamp_secs(input logic [23:0] v);
    int s0, s1, m0, m1, h0, h1;
    s0 = (v[3:0]   > 9) ? 9 : int'(v[3:0]);
    s1 = (v[7:4]   > 5) ? 5 : int'(v[7:4]);
    m0 = (v[11:8]  > 9) ? 9 : int'(v[11:8]);
    m1 = (v[15:12] > 5) ? 5 : int'(v[15:12]);
    h0 = (v[19:16] > 9) ? 9 : int'(v[19:16]);
    h1 = (v[23:20] > 2) ? 2 : int'(v[23:20]);
    if (h1 == 2 && h0 > 3) h0 = 3;
    return ((h1 * 10 + h0) * 60 + m1 * 10 + m0) * 60 + s1 * 10 + s0;
  endfunction

  function automatic logic [23:0] to_bcd(input int s);
    int h, m, sc;
    h  = s / 3600;
    m  = (s / 60) % 60;
    sc = s % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(sc / 10), 4'(sc % 10)};
  endfunction

  task automatic modelReset();
    m_state      = S_IDLE;
    m_secs       = 0;
    m_shadow     = 0;
    m_alarm_left = 0;
  endtask

  task automatic modelStep(input logic ss, input logic clr, input logic sm,
                           input logic tk, input logic [23:0] ld);
    if (clr) begin
      m_state = S_IDLE; m_secs = 0; m_alarm_left = 0;
    end else begin
      case (m_state)
        S_IDLE:  if (sm) m_state = S_SET;
                 else if (ss && m_secs > 0) m_state = S_RUN;
        S_SET:   if (sm) begin
                   m_state = S_IDLE; m_secs = clamp_secs(ld); m_shadow = m_secs;
                 end
        S_RUN:   if (ss) m_state = S_PAUSE;
                 else if (tk) begin
                   m_secs = m_secs - 1;
                   if (m_secs == 0) begin
                     m_state = S_ALARM; m_alarm_left = ALARM_SECS;
                   end
                 end
        S_PAUSE: if (ss) m_state = S_RUN;
        S_ALARM: if (ss) begin
                   m_state = S_IDLE; m_secs = 0;
                 end else if (tk) begin
                   m_alarm_left = m_alarm_left - 1;
                   if (m_alarm_left == 0) begin
`ifdef TIMER_AUTO_RELOAD_EN
                     if (m_shadow > 0) begin
                       m_state = S_RUN; m_secs = m_shadow;
                     end else begin
                       m_state = S_IDLE; m_secs = 0;
                     end
`else
                     m_state = S_IDLE; m_secs = 0;
`endif
                   end
                 end
        default: m_state = S_IDLE;
      endcase
    end
  endtask

  // Drive one clock of input pulses, advance the model and queue the
  // expected response; pulses are dropped again just after the edge.
  task automatic applyStimulus(input logic ss, input logic clr, input logic sm,
                               input logic tk, input logic [23:0] ld);
    exp_t e;
    @(negedge clk);
    start_stop = ss; clear = clr; set_mode = sm; tick_1hz = tk; ld_bcd = ld;
    modelStep(ss, clr, sm, tk, ld);
    e.st  = m_state;
    e.cur = to_bcd(m_secs);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    start_stop = 1'b0; clear = 1'b0; set_mode = 1'b0; tick_1hz = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [2:0] st,
                             input logic [23:0] cur, input logic alm);
    #1;
    n_checks++;
    if (state !== st || cur_bcd !== cur || alarm !== alm ||
        running !== (st == S_RUN) || edit_en !== (st == S_SET)) begin
      n_fail++;
      $display("[TB] FAIL %s: got state=%0d cur=%06h alarm=%b run=%b edit=%b, want state=%0d cur=%06h alarm=%b",
               name, state, cur_bcd, alarm, running, edit_en, st, cur, alm);
    end
  endtask

  task automatic loadValue(input logic [23:0] v);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, v);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, v);
  endtask

  // Monitor: every clock in which an expectation was queued, compare the
  // registered outputs shortly after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (state !== e.st || cur_bcd !== e.cur || running !== (e.st == S_RUN) ||
            alarm !== (e.st == S_ALARM) || edit_en !== (e.st == S_SET)) begin
          n_fail++;
          $display("[TB] FAIL scoreboard: got state=%0d cur=%06h run=%b alarm=%b edit=%b, want state=%0d cur=%06h",
                   state, cur_bcd, running, alarm, edit_en, e.st, e.cur);
        end
      end
    end
  end

  initial begin
    int r;
    int waitc;
    logic [23:0] ld;
    logic ss, clr, sm, tk;

    rst = 1'b0; tick_1hz = 1'b0; start_stop = 1'b0; clear = 1'b0;
    set_mode = 1'b0; ld_bcd = '0;
    modelReset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    checkOutput("reset", S_IDLE, 24'h000000, 1'b0);

    // One-minute countdown into the alarm
    loadValue(24'h000100);
    checkOutput("load_0100", S_IDLE, 24'h000100, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
    checkOutput("start", S_RUN, 24'h000100, 1'b0);
    for (int i = 1; i <= 60; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 24'h0);
      r = 60 - i;
      checkOutput("minute_tick", (i == 60) ? S_ALARM : S_RUN,
                  {16'h0000, 4'(r / 10), 4'(r % 10)}, i == 60);
    end

    // Alarm lasts ALARM_SECS ticks
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 24'h0);
    checkOutput("alarm_tick1", S_ALARM, 24'h000000, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 24'h0);
    checkOutput("alarm_tick2", S_ALARM, 24'h000000, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 24'h0);
`ifdef TIMER_AUTO_RELOAD_EN
    checkOutput("alarm_exit", S_RUN, 24'h000100, 1'b0);
`else
    checkOutput("alarm_exit", S_IDLE, 24'h000000, 1'b0);
`endif
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 24'h0);

    // Hour borrows
    loadValue(24'h100000);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 24'h0);
    checkOutput("borrow_10h", S_RUN, 24'h095959, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
    loadValue(24'h200000);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 24'h0);
    checkOutput("borrow_20h", S_RUN, 24'h195959, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 24'h0);

    // Clamp of invalid digits, then priority cases
    loadValue(24'h2F9F99);
    checkOutput("clamp", S_IDLE, 24'h235959, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 24'h0);
    checkOutput("ss_over_tick", S_PAUSE, 24'h235959, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 24'h0);
    checkOutput("clear_over_set", S_IDLE, 24'h000000, 1'b0);

    // Reset in the middle of a count
    loadValue(24'h000030);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 24'h0);
    checkOutput("pre_reset", S_RUN, 24'h000025, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    checkOutput("reset_async", S_IDLE, 24'h000000, 1'b0);
    @(posedge clk);
    checkOutput("reset_next_clk", S_IDLE, 24'h000000, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      clr = ($urandom_range(0, 199) < 2);
      sm  = ($urandom_range(0, 99) < 4);
      ss  = ($urandom_range(0, 99) < 6);
      tk  = ($urandom_range(0, 99) < 40);
      if ($urandom_range(0, 3) != 0)
        ld = {16'h0000, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 9))};
      else
        ld = 24'($urandom);
      applyStimulus(ss, clr, sm, tk, ld);
    end

    waitc = 0;
    while (exp_q.size() > 0 && waitc < 10) begin
      @(posedge clk);
      waitc++;
    end
    #2;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL drain: %0d expectations left, want 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_sequencer.md
TIMER_SEQUENCER -- requirements
Module: timer_sequencer

Interface
REQ-001 The module SHALL have one parameter: ALARM_SECS, default 10, number of 1 Hz ticks the alarm stays asserted (range 1..63).
REQ-002 The module SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port tick_1hz, input, 1 bit: one-clk-wide strobe, once per second.
REQ-005 The module SHALL have port start_stop, input, 1 bit: debounced one-clk button pulse.
REQ-006 The module SHALL have port clear, input, 1 bit: debounced one-clk button pulse.
REQ-007 The module SHALL have port set_mode, input, 1 bit: debounced one-clk pulse that toggles the edit mode.
REQ-008 The module SHALL have port ld_bcd, input, 24 bits: edited value {hrs1,hrs0,min1,min0,sec1,sec0}, 4-bit BCD each.
REQ-009 The module SHALL have port cur_bcd, output, 24 bits: remaining time, same packing as ld_bcd.
REQ-010 The module SHALL have port state, output, 3 bits: current FSM state code.
REQ-011 The module SHALL have port running, output, 1 bit: high in RUN.
REQ-012 The module SHALL have port alarm, output, 1 bit: high in ALARM.
REQ-013 The module SHALL have port edit_en, output, 1 bit: high in SET; gates the cursor/digit editor.

Function
REQ-014 The FSM SHALL have states IDLE=0, SET=1, RUN=2, PAUSE=3, ALARM=4; codes 5..7 SHALL go to IDLE on the next clk.
REQ-015 Priority among simultaneous inputs SHALL be: clear > set_mode > start_stop > tick_1hz.
REQ-016 clear SHALL, in any state, force IDLE and cur_bcd=0 on the next clk.
REQ-017 IDLE with set_mode SHALL go to SET; SET with set_mode SHALL go to IDLE and load the clamped ld_bcd into cur_bcd.
REQ-018 The load clamp SHALL be: sec0/min0/hrs0 max 9, sec1/min1 max 5, hrs1 max 2; if the clamped hrs1=2 and hrs0>3, hrs0 SHALL become 3.
REQ-019 In SET, start_stop and tick_1hz SHALL be ignored.
REQ-020 IDLE with start_stop SHALL go to RUN if cur_bcd!=0; otherwise it SHALL stay in IDLE.
REQ-021 RUN with start_stop SHALL go to PAUSE; PAUSE with start_stop SHALL go to RUN; a tick in the same cycle SHALL be dropped.
REQ-022 RUN with tick_1hz SHALL decrement cur_bcd by one second, registered, one clk of latency.
REQ-023 The decrement SHALL borrow: sec0 0->9, sec1 0->5, min0 0->9, min1 0->5, then hours in decimal 00..23.
REQ-024 A decrement from 00:00:01 to 0 SHALL move to ALARM in the same clk and load alarm_cnt=ALARM_SECS.
REQ-025 In ALARM, each tick SHALL decrement alarm_cnt; when alarm_cnt reaches 0, or on start_stop, the FSM SHALL exit ALARM.
REQ-026 Outputs running, alarm and edit_en SHALL be decoded from registered state, glitch-free.

Reset
REQ-027 While rst=0, the block SHALL hold state=IDLE, cur_bcd=0, alarm_cnt=0, a shadow reload register=0, and running=alarm=edit_en=0.
REQ-028 Assertion of rst mid-count SHALL abort the count immediately, with no alarm.

Configuration
REQ-029 With TIMER_AUTO_RELOAD_EN defined, each load SHALL also store the value in a shadow register, and the ALARM exit SHALL reload cur_bcd from the shadow and go to RUN; start_stop in ALARM SHALL still go to IDLE.
REQ-030 Without TIMER_AUTO_RELOAD_EN, the shadow register SHALL be absent and every ALARM exit SHALL go to IDLE with cur_bcd=0.

Structure
REQ-031 Package timer_pkg SHALL hold the state encoding, the digit-max constants (9, 5, 2, 3) and the BCD packing field offsets.
REQ-032 The BCD one-second decrement SHALL be a combinational sub-module, timer_bcd_dec (24-bit in, 24-bit out, zero flag).

Verification
REQ-033 Bench SHALL check: ld_bcd=00:01:00, set_mode x2, start_stop, 60 ticks -> cur_bcd steps 00:00:59..00:00:00, alarm=1 on the 60th tick.
REQ-034 Bench SHALL check: cur_bcd=10:00:00, one tick in RUN -> 09:59:59; cur_bcd=20:00:00 -> 19:59:59.
REQ-035 Bench SHALL check: ld_bcd=2F:9F:99 (invalid digits) loaded -> cur_bcd=23:59:59.
REQ-036 Bench SHALL check: start_stop and tick in the same clk in RUN -> PAUSE, value unchanged; clear and set_mode in the same clk -> IDLE, cur_bcd=0.
REQ-037 Bench SHALL check: ALARM_SECS=3 -> alarm high for exactly 3 ticks, then IDLE (RUN with the reloaded value if TIMER_AUTO_RELOAD_EN).
REQ-038 Bench SHALL check: rst pulse low mid-RUN -> next clk shows state=IDLE, cur_bcd=0, alarm=0.
